issue_queue_int: RTL

Integer issue queue sitting between dispatch and the `issue` block. It holds up to DEPTH integer instructions and snoops the CDB to capture missing source operands. It presents the oldest fully-ready entry to the issue unit through the `issueint_ready` / `issueint_equeueint_done` handshake, and compacts itself on each issue. It is the consumer end of the CDB and the producer end of the integer issue handshake.

---
 rtl/issue_queue_int.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/issue_queue_int.sv
// Integer issue queue: in-order compacting storage, CDB snoop with dispatch bypass,
// oldest-ready select presented to the integer issue unit.
module issue_queue_int #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            dispatch_en,
    input  logic [5:0]      dispatch_opcode,
    input  logic [TAGW-1:0] dispatch_rdtag,
    input  logic [TAGW-1:0] dispatch_rstag,
    input  logic [TAGW-1:0] dispatch_rttag,
    input  logic [31:0]     dispatch_rsdata,
    input  logic [31:0]     dispatch_rtdata,
    input  logic            dispatch_rsvalid,
    input  logic            dispatch_rtvalid,
    output logic            queue_full,
    input  logic            cdb_valid,
    input  logic [TAGW-1:0] cdb_tag,
    input  logic [31:0]     cdb_data,
    output logic            issueint_ready,
    output logic [5:0]      issueint_opcode,
    output logic [31:0]     issueint_rsdata,
    output logic [31:0]     issueint_rtdata,
    output logic [TAGW-1:0] issueint_rdtag,
    input  logic            issueint_equeueint_done
);

    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int IDXW = $clog2(DEPTH);

    typedef struct packed {
        logic            valid;
        logic [5:0]      opcode;
        logic [TAGW-1:0] rdtag;
        logic [TAGW-1:0] rstag;
        logic [31:0]     rsdata;
        logic            rsvalid;
        logic [TAGW-1:0] rttag;
        logic [31:0]     rtdata;
        logic            rtvalid;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    entry_t            new_ent;
    logic [CNTW-1:0]   count_q, count_d;
    logic [CNTW-1:0]   wr_idx;
    logic [DEPTH-1:0]  ready;
    logic [IDXW-1:0]   sel_idx;
    logic              issue;
    logic              do_dispatch;

    assign queue_full = (count_q == CNTW'(DEPTH));

    // Select looks at registered state only, so a CDB wakeup presents one cycle later.
    always_comb begin
        ready   = '0;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = ent_q[i].valid & ent_q[i].rsvalid & ent_q[i].rtvalid;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) sel_idx = IDXW'(i);
        end
        issueint_ready  = |ready;
        issueint_opcode = '0;
        issueint_rsdata = '0;
        issueint_rtdata = '0;
        issueint_rdtag  = '0;
        if (issueint_ready) begin
            issueint_opcode = ent_q[sel_idx].opcode;
            issueint_rsdata = ent_q[sel_idx].rsdata;
            issueint_rtdata = ent_q[sel_idx].rtdata;
            issueint_rdtag  = ent_q[sel_idx].rdtag;
        end
    end

    always_comb begin
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.opcode  = dispatch_opcode;
        new_ent.rdtag   = dispatch_rdtag;
        new_ent.rstag   = dispatch_rstag;
        new_ent.rsdata  = dispatch_rsdata;
        new_ent.rsvalid = dispatch_rsvalid;
        new_ent.rttag   = dispatch_rttag;
        new_ent.rtdata  = dispatch_rtdata;
        new_ent.rtvalid = dispatch_rtvalid;
        if (!dispatch_rsvalid && cdb_valid && dispatch_rstag == cdb_tag) begin
            new_ent.rsdata  = cdb_data;
            new_ent.rsvalid = 1'b1;
        end
        if (!dispatch_rtvalid && cdb_valid && dispatch_rttag == cdb_tag) begin
            new_ent.rtdata  = cdb_data;
            new_ent.rtvalid = 1'b1;
        end
    end

    // NOTE: combinational next-state uses blocking '=' with every target defaulted first,
    // so later statements (shift, snoop, dispatch, flush) layer cleanly and no latch forms.
    always_comb begin
        issue       = issueint_equeueint_done & issueint_ready;
        do_dispatch = dispatch_en & ~queue_full;
        wr_idx      = issue ? count_q - 1'b1 : count_q;
        count_d     = count_q;
        for (int j = 0; j < DEPTH; j++) ent_d[j] = ent_q[j];

        for (int j = 0; j < DEPTH - 1; j++) begin
            if (issue && j >= int'(sel_idx)) ent_d[j] = ent_q[j+1];
        end
        if (issue) ent_d[DEPTH-1].valid = 1'b0;

        for (int j = 0; j < DEPTH; j++) begin
            if (cdb_valid && ent_d[j].valid) begin
                if (!ent_d[j].rsvalid && ent_d[j].rstag == cdb_tag) begin
                    ent_d[j].rsdata  = cdb_data;
                    ent_d[j].rsvalid = 1'b1;
                end
                if (!ent_d[j].rtvalid && ent_d[j].rttag == cdb_tag) begin
                    ent_d[j].rtdata  = cdb_data;
                    ent_d[j].rtvalid = 1'b1;
                end
            end
        end

        for (int j = 0; j < DEPTH; j++) begin
            if (do_dispatch && j == int'(wr_idx)) ent_d[j] = new_ent;
        end

        if (do_dispatch && !issue)      count_d = count_q + 1'b1;
        else if (!do_dispatch && issue) count_d = count_q - 1'b1;

        if (flush) begin
            count_d = '0;
            for (int j = 0; j < DEPTH; j++) ent_d[j].valid = 1'b0;
        end
    end

    // NOTE: only the valid bits and count are reset; payload fields are don't-care
    // while invalid, so they stay plain data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int j = 0; j < DEPTH; j++) ent_q[j].valid <= 1'b0;
        end else begin
            count_q <= count_d;
            for (int j = 0; j < DEPTH; j++) ent_q[j] <= ent_d[j];
        end
    end

endmodule
